// File: rtl/l1_miss_scheduler.sv
// l1_miss_scheduler: round-robin arbiter that forwards I-cache / D-cache
// refill and write-back requests to the single L2 port, one transaction at a
// time, routing the response back to the owner and guarding it with a watchdog.
module l1_miss_scheduler #(
  parameter int ADDR_W      = 32,
  parameter int LINE_W      = 128,
  parameter int TIMEOUT_CYC = 1024,
  parameter int CNT_W       = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              ic_valid_i,
  input  logic              ic_rw_i,
  input  logic [ADDR_W-1:0] ic_addr_i,
  input  logic [LINE_W-1:0] ic_wdata_i,
  output logic              ic_ready_o,
  output logic [LINE_W-1:0] ic_rdata_o,
  input  logic              dc_valid_i,
  input  logic              dc_rw_i,
  input  logic [ADDR_W-1:0] dc_addr_i,
  input  logic [LINE_W-1:0] dc_wdata_i,
  output logic              dc_ready_o,
  output logic [LINE_W-1:0] dc_rdata_o,
  output logic              l2_valid_o,
  output logic              l2_rw_o,
  output logic [ADDR_W-1:0] l2_addr_o,
  output logic [LINE_W-1:0] l2_wdata_o,
  input  logic              l2_ready_i,
  input  logic [LINE_W-1:0] l2_rdata_i,
  output logic              owner_o,
  output logic              busy_o,
  output logic              timeout_o,
  output logic [CNT_W-1:0]  ic_grants_o,
  output logic [CNT_W-1:0]  dc_grants_o
);

  // Watchdog counter only needs to reach TIMEOUT_CYC-1.
  localparam bit WD_ON      = (TIMEOUT_CYC > 0);
  localparam int WD_W       = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int WD_LAST_I  = WD_ON ? (TIMEOUT_CYC - 1) : 0;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WD_LAST_I);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t            state, state_nxt;
  logic              last_grant;   // 0=I-cache, 1=D-cache
  logic              owner;
  logic              rw;
  logic [ADDR_W-1:0] addr;
  logic [LINE_W-1:0] wdata;
  logic [CNT_W-1:0]  ic_grants, dc_grants;
  logic [WD_W-1:0]   wd;
  logic              timeout;

  logic              grant_en;
  logic              grant_sel;
  logic              wd_expire;

  // State register; reset abandons any transaction in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state, arbitration and response routing.
  always_comb begin
    state_nxt  = state;
    grant_en   = 1'b0;
    grant_sel  = 1'b0;
    wd_expire  = 1'b0;
    ic_ready_o = 1'b0;
    dc_ready_o = 1'b0;
    ic_rdata_o = '0;
    dc_rdata_o = '0;
    case (state)
      IDLE: begin
        // On a tie the requester that did not win last time is served.
        grant_sel = (ic_valid_i && dc_valid_i) ? ~last_grant : dc_valid_i;
        grant_en  = ic_valid_i || dc_valid_i;
        if (grant_en) state_nxt = ISSUE;
      end
      ISSUE: begin
        // A real response in the expiry cycle takes precedence over the timeout.
        wd_expire = WD_ON && (wd == WD_LAST) && !l2_ready_i;
        if (l2_ready_i || wd_expire) begin
          state_nxt = IDLE;
          if (owner) begin
            dc_ready_o = 1'b1;
            dc_rdata_o = l2_ready_i ? l2_rdata_i : '0;
          end else begin
            ic_ready_o = 1'b1;
            ic_rdata_o = l2_ready_i ? l2_rdata_i : '0;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request latch, grant counters, watchdog and sticky timeout flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_grant <= 1'b1;
      owner      <= 1'b0;
      rw         <= 1'b0;
      addr       <= '0;
      wdata      <= '0;
      ic_grants  <= '0;
      dc_grants  <= '0;
      wd         <= '0;
      timeout    <= 1'b0;
    end else begin
      if (grant_en) begin
        owner      <= grant_sel;
        last_grant <= grant_sel;
        rw         <= grant_sel ? dc_rw_i    : ic_rw_i;
        addr       <= grant_sel ? dc_addr_i  : ic_addr_i;
        wdata      <= grant_sel ? dc_wdata_i : ic_wdata_i;
        wd         <= '0;
        if (grant_sel) dc_grants <= dc_grants + CNT_W'(1);
        else           ic_grants <= ic_grants + CNT_W'(1);
      end else if (state == ISSUE && !l2_ready_i) begin
        wd <= wd + WD_W'(1);
      end
      if (wd_expire) timeout <= 1'b1;
    end
  end

  assign l2_valid_o  = (state == ISSUE);
  assign busy_o      = (state != IDLE);
  assign l2_rw_o     = rw;
  assign l2_addr_o   = addr;
  assign l2_wdata_o  = wdata;
  assign owner_o     = owner;
  assign timeout_o   = timeout;
  assign ic_grants_o = ic_grants;
  assign dc_grants_o = dc_grants;

endmodule

// File: tb/tb_l1_miss_scheduler.sv
// Directed bench for l1_miss_scheduler: reset, single read, tie alternation,
// write-back latching, watchdog expiry, response/expiry race, reset mid-issue.
module tb_l1_miss_scheduler;

  localparam int ADDR_W = 32;
  localparam int LINE_W = 128;
  localparam int CNT_W  = 32;
  localparam int TO     = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              ic_valid, ic_rw, dc_valid, dc_rw;
  logic [ADDR_W-1:0] ic_addr, dc_addr;
  logic [LINE_W-1:0] ic_wdata, dc_wdata;
  logic              ic_ready, dc_ready;
  logic [LINE_W-1:0] ic_rdata, dc_rdata;
  logic              l2_valid, l2_rw, l2_ready;
  logic [ADDR_W-1:0] l2_addr;
  logic [LINE_W-1:0] l2_wdata, l2_rdata;
  logic              owner, busy, timeout;
  logic [CNT_W-1:0]  ic_grants, dc_grants;

  int checks = 0;
  int errors = 0;

  l1_miss_scheduler #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .TIMEOUT_CYC(TO), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .ic_valid_i(ic_valid), .ic_rw_i(ic_rw), .ic_addr_i(ic_addr), .ic_wdata_i(ic_wdata),
    .ic_ready_o(ic_ready), .ic_rdata_o(ic_rdata),
    .dc_valid_i(dc_valid), .dc_rw_i(dc_rw), .dc_addr_i(dc_addr), .dc_wdata_i(dc_wdata),
    .dc_ready_o(dc_ready), .dc_rdata_o(dc_rdata),
    .l2_valid_o(l2_valid), .l2_rw_o(l2_rw), .l2_addr_o(l2_addr), .l2_wdata_o(l2_wdata),
    .l2_ready_i(l2_ready), .l2_rdata_i(l2_rdata),
    .owner_o(owner), .busy_o(busy), .timeout_o(timeout),
    .ic_grants_o(ic_grants), .dc_grants_o(dc_grants)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    ic_valid = 0; ic_rw = 0; ic_addr = '0; ic_wdata = '0;
    dc_valid = 0; dc_rw = 0; dc_addr = '0; dc_wdata = '0;
    l2_ready = 0; l2_rdata = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 0;
    step();
    rst_n = 1;
    step();
  endtask

  task automatic test_reset();
    rst_n = 0;
    clear_inputs();
    #3;
    checks++; if (l2_valid !== 1'b0) begin errors++; $display("FAIL rst_l2_valid got %0b want 0", l2_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %0b want 0", busy); end
    checks++; if ({ic_grants, dc_grants} !== '0) begin errors++; $display("FAIL rst_counters got %0h/%0h want 0", ic_grants, dc_grants); end
    checks++; if ({timeout, owner, l2_rw} !== 3'b000) begin errors++; $display("FAIL rst_flags got %b want 000", {timeout, owner, l2_rw}); end
    checks++; if (l2_addr !== '0 || l2_wdata !== '0) begin errors++; $display("FAIL rst_latch got %0h/%0h want 0", l2_addr, l2_wdata); end
    step();
    rst_n = 1;
    step();
  endtask

  task automatic test_single_read();
    logic [LINE_W-1:0] d;
    d = {16{8'hA5}};
    ic_valid = 1; ic_rw = 0; ic_addr = 32'h0000_0040;
    #1;
    checks++; if (l2_valid !== 1'b0) begin errors++; $display("FAIL rd_pre_valid got %0b want 0", l2_valid); end
    step();
    checks++; if (l2_valid !== 1'b1 || l2_addr !== 32'h40 || l2_rw !== 1'b0) begin errors++; $display("FAIL rd_issue got v=%0b a=%0h rw=%0b want 1/40/0", l2_valid, l2_addr, l2_rw); end
    checks++; if (ic_grants !== 1 || owner !== 1'b0) begin errors++; $display("FAIL rd_grant got cnt=%0d own=%0b want 1/0", ic_grants, owner); end
    for (int i = 0; i < 5; i++) step();
    l2_ready = 1; l2_rdata = d;
    #1;
    checks++; if (ic_ready !== 1'b1 || ic_rdata !== d) begin errors++; $display("FAIL rd_resp got r=%0b d=%0h want 1/%0h", ic_ready, ic_rdata, d); end
    checks++; if (dc_ready !== 1'b0 || dc_rdata !== '0) begin errors++; $display("FAIL rd_other got r=%0b d=%0h want 0/0", dc_ready, dc_rdata); end
    step();
    l2_ready = 0; l2_rdata = '0; ic_valid = 0;
    #1;
    checks++; if (ic_ready !== 1'b0 || ic_rdata !== '0 || l2_valid !== 1'b0) begin errors++; $display("FAIL rd_after got r=%0b d=%0h v=%0b want 0/0/0", ic_ready, ic_rdata, l2_valid); end
    step();
  endtask

  task automatic test_back_to_back();
    do_reset();
    ic_valid = 1; ic_addr = 32'h100; dc_valid = 1; dc_addr = 32'h200;
    step();
    checks++; if (owner !== 1'b0 || l2_addr !== 32'h100) begin errors++; $display("FAIL tie1 got own=%0b a=%0h want 0/100", owner, l2_addr); end
    l2_ready = 1; l2_rdata = 128'h11;
    #1;
    checks++; if (ic_ready !== 1'b1 || dc_ready !== 1'b0) begin errors++; $display("FAIL tie1_resp got ic=%0b dc=%0b want 1/0", ic_ready, dc_ready); end
    step();
    l2_ready = 0; ic_valid = 0;
    #1;
    checks++; if (l2_valid !== 1'b0) begin errors++; $display("FAIL gap got v=%0b want 0", l2_valid); end
    step();
    checks++; if (owner !== 1'b1 || l2_addr !== 32'h200 || dc_grants !== 1) begin errors++; $display("FAIL tie2 got own=%0b a=%0h dcg=%0d want 1/200/1", owner, l2_addr, dc_grants); end
    l2_ready = 1; l2_rdata = 128'h22;
    #1;
    checks++; if (dc_ready !== 1'b1 || dc_rdata !== 128'h22 || ic_ready !== 1'b0) begin errors++; $display("FAIL tie2_resp got dc=%0b d=%0h ic=%0b want 1/22/0", dc_ready, dc_rdata, ic_ready); end
    step();
    l2_ready = 0; dc_valid = 0;
    step();
    ic_valid = 1; ic_addr = 32'h300; dc_valid = 1; dc_addr = 32'h400;
    step();
    checks++; if (owner !== 1'b0 || l2_addr !== 32'h300 || ic_grants !== 2) begin errors++; $display("FAIL tie3 got own=%0b a=%0h icg=%0d want 0/300/2", owner, l2_addr, ic_grants); end
    l2_ready = 1;
    step();
    l2_ready = 0; ic_valid = 0; dc_valid = 0;
    step();
    checks++; if (busy !== 1'b0 || dc_grants !== 1) begin errors++; $display("FAIL tie_end got busy=%0b dcg=%0d want 0/1", busy, dc_grants); end
  endtask

  task automatic test_writeback();
    logic [LINE_W-1:0] w;
    w = {8{16'hDEAD}};
    dc_valid = 1; dc_rw = 1; dc_addr = 32'h0000_1000; dc_wdata = w;
    step();
    checks++; if (l2_rw !== 1'b1 || l2_wdata !== w || l2_addr !== 32'h1000) begin errors++; $display("FAIL wb_issue got rw=%0b a=%0h want 1/1000", l2_rw, l2_addr); end
    dc_wdata = ~w; dc_addr = 32'hFFFF_0000; dc_rw = 0;
    step();
    dc_wdata = w ^ 128'h5;
    step();
    checks++; if (l2_wdata !== w || l2_addr !== 32'h1000 || l2_rw !== 1'b1) begin errors++; $display("FAIL wb_hold got a=%0h w=%0h want 1000/%0h", l2_addr, l2_wdata, w); end
    l2_ready = 1; l2_rdata = 128'h77;
    #1;
    checks++; if (dc_ready !== 1'b1 || dc_rdata !== 128'h77) begin errors++; $display("FAIL wb_resp got r=%0b d=%0h want 1/77", dc_ready, dc_rdata); end
    step();
    l2_ready = 0; l2_rdata = '0; dc_valid = 0; dc_rw = 0;
    step();
  endtask

  task automatic test_timeout();
    int  n;
    bit  found;
    do_reset();
    ic_valid = 1; ic_addr = 32'h500;
    step();
    checks++; if (l2_valid !== 1'b1 || timeout !== 1'b0) begin errors++; $display("FAIL to_entry got v=%0b to=%0b want 1/0", l2_valid, timeout); end
    n = 0; found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (ic_ready === 1'b1) found = 1;
      else begin step(); n++; end
    end
    checks++; if (!found || n != TO - 1) begin errors++; $display("FAIL to_latency got found=%0b extra_cycles=%0d want 1/%0d", found, n, TO - 1); end
    checks++; if (ic_rdata !== '0 || dc_ready !== 1'b0 || l2_valid !== 1'b1) begin errors++; $display("FAIL to_pulse got d=%0h dc=%0b v=%0b want 0/0/1", ic_rdata, dc_ready, l2_valid); end
    step();
    ic_valid = 0;
    #1;
    checks++; if (timeout !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL to_flag got to=%0b busy=%0b want 1/0", timeout, busy); end
    for (int i = 0; i < 3; i++) step();
    checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL to_sticky got %0b want 1", timeout); end
  endtask

  task automatic test_race();
    logic [LINE_W-1:0] d;
    d = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321;
    do_reset();
    ic_valid = 1; ic_addr = 32'h600;
    step();
    for (int i = 0; i < TO - 1; i++) step();
    l2_ready = 1; l2_rdata = d;
    #1;
    checks++; if (ic_ready !== 1'b1 || ic_rdata !== d) begin errors++; $display("FAIL race_resp got r=%0b d=%0h want 1/%0h", ic_ready, ic_rdata, d); end
    step();
    l2_ready = 0; l2_rdata = '0; ic_valid = 0;
    step();
    checks++; if (timeout !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL race_flag got to=%0b busy=%0b want 0/0", timeout, busy); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    dc_valid = 1; dc_rw = 1; dc_addr = 32'h700; dc_wdata = 128'hAB;
    step();
    step(); step();
    rst_n = 0;
    #1;
    checks++; if (l2_valid !== 1'b0 || busy !== 1'b0 || dc_grants !== '0) begin errors++; $display("FAIL rmid_async got v=%0b b=%0b dcg=%0d want 0/0/0", l2_valid, busy, dc_grants); end
    checks++; if (l2_addr !== '0 || l2_wdata !== '0 || l2_rw !== 1'b0 || owner !== 1'b0) begin errors++; $display("FAIL rmid_latch got a=%0h rw=%0b own=%0b want 0/0/0", l2_addr, l2_rw, owner); end
    dc_rw = 0;
    ic_valid = 1; ic_addr = 32'h800;
    step();
    rst_n = 1;
    step();
    checks++; if (l2_valid !== 1'b1 || owner !== 1'b0 || l2_addr !== 32'h800 || ic_grants !== 1) begin errors++; $display("FAIL rmid_regrant got v=%0b own=%0b a=%0h icg=%0d want 1/0/800/1", l2_valid, owner, l2_addr, ic_grants); end
    l2_ready = 1; l2_rdata = 128'h99;
    #1;
    checks++; if (ic_ready !== 1'b1 || ic_rdata !== 128'h99) begin errors++; $display("FAIL rmid_resp got r=%0b d=%0h want 1/99", ic_ready, ic_rdata); end
    step();
    l2_ready = 0; ic_valid = 0;
    step();
    checks++; if (owner !== 1'b1 || dc_grants !== 1) begin errors++; $display("FAIL rmid_pending got own=%0b dcg=%0d want 1/1", owner, dc_grants); end
    l2_ready = 1;
    step();
    l2_ready = 0; dc_valid = 0;
    step();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_back_to_back();
    test_writeback();
    test_timeout();
    test_race();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
